// File: rtl/comb_lock_ctrl.sv
// Combination lock sequencer: entry check, failed-attempt lockout and two-step combination change.
// Acts on key rising edges in the same cycle they are sampled; all outputs are registered.
module comb_lock_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] x,
    input  logic       enter,
    input  logic       change,
    input  logic [3:0] stored_comb,
    output logic       unlocked,
    output logic       alarm,
    output logic       set_comb,
    output logic [3:0] comb_out,
    output logic [1:0] fail_cnt
);

    localparam logic [1:0] TRIES_LIM  = 2'(MAX_TRIES);
    localparam logic [7:0] UNLOCK_LD  = 8'(UNLOCK_CYCLES);
    localparam logic [7:0] LOCKOUT_LD = 8'(LOCKOUT_CYCLES);

    typedef enum logic [2:0] {
        LOCKED, OPEN, CHG_NEW, CHG_CONFIRM, COMMIT, LOCKOUT
    } state_t;

    state_t     state;
    logic [7:0] timer;
    logic       enter_q;
    logic       change_q;
    logic       enter_e;
    logic       change_e;
    logic [1:0] fail_inc;

    assign enter_e  = enter & ~enter_q;
    assign change_e = change & ~change_q;
    assign fail_inc = fail_cnt + 2'd1;

    // Outputs default low each cycle and are re-asserted from the state being entered.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= LOCKED;
            timer    <= 8'd0;
            enter_q  <= 1'b0;
            change_q <= 1'b0;
            unlocked <= 1'b0;
            alarm    <= 1'b0;
            set_comb <= 1'b0;
            fail_cnt <= 2'd0;
            comb_out <= 4'b0110;
        end else begin
            enter_q  <= enter;
            change_q <= change;
            unlocked <= 1'b0;
            alarm    <= 1'b0;
            set_comb <= 1'b0;
            case (state)
                LOCKED: begin
                    if (enter_e) begin
                        if (x == stored_comb) begin
                            state    <= OPEN;
                            fail_cnt <= 2'd0;
                            timer    <= UNLOCK_LD;
                            unlocked <= 1'b1;
                        end else begin
                            fail_cnt <= fail_inc;
                            if (fail_inc == TRIES_LIM) begin
                                state <= LOCKOUT;
                                timer <= LOCKOUT_LD;
                                alarm <= 1'b1;
                            end
                        end
                    end
                end
                OPEN: begin
                    if (change_e) begin
                        state <= CHG_NEW;
                        timer <= 8'd0;
                    end else if (enter_e || timer == 8'd1) begin
                        state <= LOCKED;
                        timer <= 8'd0;
                    end else begin
                        timer    <= timer - 8'd1;
                        unlocked <= 1'b1;
                    end
                end
                CHG_NEW: begin
                    if (change_e) begin
                        state <= LOCKED;
                    end else if (enter_e) begin
                        comb_out <= x;
                        state    <= CHG_CONFIRM;
                    end
                end
                CHG_CONFIRM: begin
                    if (change_e) begin
                        state <= LOCKED;
                    end else if (enter_e) begin
                        if (x == comb_out) begin
                            state    <= COMMIT;
                            set_comb <= 1'b1;
                        end else begin
                            state <= LOCKED;
                        end
                    end
                end
                COMMIT: state <= LOCKED;
                LOCKOUT: begin
                    if (timer == 8'd1) begin
                        state    <= LOCKED;
                        timer    <= 8'd0;
                        fail_cnt <= 2'd0;
                    end else begin
                        timer <= timer - 8'd1;
                        alarm <= 1'b1;
                    end
                end
                default: state <= LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_comb_lock_ctrl.sv
// Directed bench for comb_lock_ctrl with a behavioural model of the combination store register.
module tb_comb_lock_ctrl;

    logic       Clock;
    logic       Reset;
    logic [3:0] x;
    logic       enter;
    logic       change;
    logic [3:0] stored_comb;
    logic       unlocked;
    logic       alarm;
    logic       set_comb;
    logic [3:0] comb_out;
    logic [1:0] fail_cnt;

    int n_vec = 0;
    int n_err = 0;
    int unl_n = 0;
    int alm_n = 0;
    int set_n = 0;

    comb_lock_ctrl #(
        .MAX_TRIES(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
    ) dut (
        .Clock(Clock), .Reset(Reset), .x(x), .enter(enter), .change(change),
        .stored_comb(stored_comb), .unlocked(unlocked), .alarm(alarm),
        .set_comb(set_comb), .comb_out(comb_out), .fail_cnt(fail_cnt)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Store register: edge-triggered load on set_comb, resets to 0110.
    always @(posedge set_comb or posedge Reset) begin
        if (Reset) stored_comb <= 4'b0110;
        else       stored_comb <= comb_out;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        unl_n += int'(unlocked);
        alm_n += int'(alarm);
        set_n += int'(set_comb);
    endtask

    task automatic clr();
        unl_n = 0;
        alm_n = 0;
        set_n = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic [3:0] v);
        x = v;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    task automatic press_chg();
        change = 1'b1;
        step();
        change = 1'b0;
        step();
    endtask

    initial begin
        Reset = 1'b1; x = 4'd0; enter = 1'b0; change = 1'b0;
        steps(2);
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_set", int'(set_comb), 0);
        chk("rst_fail", int'(fail_cnt), 0);
        chk("rst_comb", int'(comb_out), 6);
        Reset = 1'b0;
        steps(2);

        // correct entry: open for exactly 8 cycles
        clr();
        x = 4'b0110; enter = 1'b1;
        step();
        chk("open_now", int'(unlocked), 1);
        enter = 1'b0;
        steps(12);
        chk("open_len", unl_n, 8);
        chk("open_after", int'(unlocked), 0);
        chk("open_fail", int'(fail_cnt), 0);

        // lockout after three wrong entries; entries during lockout ignored
        press(4'b0001);
        chk("fail1", int'(fail_cnt), 1);
        press(4'b0001);
        chk("fail2", int'(fail_cnt), 2);
        chk("no_alarm_yet", int'(alarm), 0);
        clr();
        x = 4'b0001; enter = 1'b1;
        step();
        chk("alarm_now", int'(alarm), 1);
        enter = 1'b0;
        step();
        press(4'b0110);
        chk("lock_ignore", int'(unlocked), 0);
        steps(18);
        chk("alarm_len", alm_n, 16);
        chk("lock_unl", unl_n, 0);
        chk("alarm_after", int'(alarm), 0);
        chk("fail_after", int'(fail_cnt), 0);

        // change success
        press(4'b0110);
        clr();
        press_chg();
        chk("chg_closes", int'(unlocked), 0);
        press(4'b1010);
        chk("pend_comb", int'(comb_out), 10);
        press(4'b1010);
        steps(3);
        chk("set_pulses", set_n, 1);
        chk("new_store", int'(stored_comb), 10);
        press(4'b1010);
        chk("new_unlock", int'(unlocked), 1);
        press(4'b1010);
        chk("relock", int'(unlocked), 0);
        press(4'b0110);
        chk("old_fails", int'(fail_cnt), 1);
        press(4'b1010);
        chk("new_clr_fail", int'(fail_cnt), 0);
        press(4'b1010);

        // confirm mismatch: back to LOCKED, no strobe, fail_cnt untouched
        press(4'b1010);
        clr();
        press_chg();
        press(4'b1100);
        press(4'b1011);
        steps(2);
        chk("mm_set", set_n, 0);
        chk("mm_store", int'(stored_comb), 10);
        chk("mm_fail", int'(fail_cnt), 0);
        press(4'b1010);
        chk("mm_locked", int'(unlocked), 1);
        press(4'b1010);

        // abort from CHG_NEW
        press(4'b1010);
        press_chg();
        press_chg();
        press(4'b1010);
        chk("abort_locked", int'(unlocked), 1);
        press(4'b1010);

        // reset in CHG_CONFIRM
        press(4'b1010);
        clr();
        press_chg();
        press(4'b0011);
        chk("pre_rst_comb", int'(comb_out), 3);
        Reset = 1'b1;
        step();
        chk("mid_rst_comb", int'(comb_out), 6);
        chk("mid_rst_unl", int'(unlocked), 0);
        chk("mid_rst_fail", int'(fail_cnt), 0);
        Reset = 1'b0;
        steps(2);
        chk("mid_rst_set", set_n, 0);
        press(4'b0011);
        chk("rst_no_commit", int'(fail_cnt), 1);
        press(4'b0110);
        chk("rst_store_ok", int'(unlocked), 1);

        // held enter: one action only
        x = 4'b0110; enter = 1'b1;
        steps(10);
        chk("held_relock", int'(unlocked), 0);
        enter = 1'b0;
        step();
        x = 4'b0001; enter = 1'b1;
        steps(10);
        chk("held_fail", int'(fail_cnt), 1);
        enter = 1'b0;
        step();

        // enter and change together in OPEN: change wins
        press(4'b0110);
        clr();
        x = 4'b0110; enter = 1'b1; change = 1'b1;
        step();
        enter = 1'b0; change = 1'b0;
        step();
        press(4'b1001);
        chk("prio_capture", int'(comb_out), 9);
        chk("prio_unl", int'(unlocked), 0);
        press_chg();
        steps(2);
        chk("prio_set", set_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/comb_lock_ctrl.md
# comb_lock_ctrl

Sequencing controller for the combination lock. It compares entered 4-bit codes against the stored combination and drives the unlock and alarm outputs. It enforces a failed-attempt lockout and runs the two-step change-combination procedure that strobes the 4-bit combination store register. It sits between the user inputs (switches plus enter/change keys, already synchronised to `Clock`) and the combination store register, whose `Y` output feeds back as `stored_comb`.

## Interface
- `MAX_TRIES`, 3: consecutive wrong entries that trigger lockout; legal range 1..3.
- `UNLOCK_CYCLES`, 8: cycles `unlocked` stays high after a correct entry; legal range 1..255.
- `LOCKOUT_CYCLES`, 16: cycles `alarm` stays high after lockout; legal range 1..255.

- `Clock` in 1: single clock. All logic is on the posedge.
- `Reset` in 1: asynchronous, active-high reset.
- `x` in 4: entered code.
- `enter` in 1: enter key, level. The controller acts on its rising edge.
- `change` in 1: change-combination key, level. The controller acts on its rising edge.
- `stored_comb` in 4: current combination from the store register.
- `unlocked` out 1: lock open.
- `alarm` out 1: lockout active.
- `set_comb` out 1: one-cycle strobe. Its rising edge loads `comb_out` into the store register.
- `comb_out` out 4: registered value of the new combination.
- `fail_cnt` out 2: current count of consecutive failed entries.

## Operation
- Edge detect:
  - `enter_q` and `change_q` are registered copies of the inputs.
  - `enter_e = enter & ~enter_q`.
  - `change_e = change & ~change_q`.
  - Edge detectors update in every state, including LOCKOUT.
- States: LOCKED, OPEN, CHG_NEW, CHG_CONFIRM, COMMIT, LOCKOUT.
- LOCKED:
  - On `enter_e` with `x == stored_comb`: go to OPEN, clear `fail_cnt`, load timer with `UNLOCK_CYCLES`.
  - On `enter_e` with a mismatch: increment `fail_cnt`.
  - If the incremented count equals `MAX_TRIES`: go to LOCKOUT, load timer with `LOCKOUT_CYCLES`.
  - `change_e` is ignored.
- OPEN:
  - `unlocked` = 1. The timer decrements each cycle.
  - When timer = 1 and it is about to decrement: go to LOCKED.
  - On `change_e`: go to CHG_NEW and stop the timer.
  - On `enter_e`: relock immediately (go to LOCKED).
  - If `change_e` and `enter_e` occur in the same cycle, `change_e` wins.
- CHG_NEW:
  - On `enter_e`: capture `x` into the pending register. `comb_out` reflects the pending register from the next cycle. Go to CHG_CONFIRM.
  - On `change_e`: abort to LOCKED. The pending register keeps its old value.
- CHG_CONFIRM:
  - On `enter_e` with `x == comb_out`: go to COMMIT.
  - On `enter_e` with a mismatch: go to LOCKED. No strobe is issued and `fail_cnt` is unchanged.
  - On `change_e`: abort to LOCKED.
- COMMIT:
  - `set_comb` = 1 for exactly this one cycle.
  - Next state is LOCKED unconditionally.
- LOCKOUT:
  - `alarm` = 1. The timer decrements each cycle.
  - Go to LOCKED when the timer expires, clearing `fail_cnt`.
  - `enter_e` and `change_e` are ignored.
- `unlocked`, `alarm` and `set_comb` are decoded from state and registered, so they are glitch-free.
- Simultaneous `enter_e` and `change_e`: where both are defined, `change_e` has priority. Otherwise only the defined one acts.

## Timing
- Reset values:
  - State = LOCKED.
  - `unlocked` = `alarm` = `set_comb` = 0.
  - `fail_cnt` = 0.
  - `comb_out` = 4'b0110, matching the store register's reset value.
  - Timer = 0, `enter_q` = `change_q` = 0.
- Reset asserted mid-operation aborts any change sequence immediately. No `set_comb` pulse is generated.
- An input edge sampled at posedge n produces its state and output change at posedge n (visible after n). Decision latency is 1 cycle from the input rising.
- `unlocked` is high for exactly `UNLOCK_CYCLES` cycles unless cut short by `enter_e` or `change_e`.
- `alarm` is high for exactly `LOCKOUT_CYCLES` cycles.
- `comb_out` is stable for at least 1 cycle before the `set_comb` rise, and until the next capture. This meets the store register's edge-triggered load.
- `set_comb` is high for exactly 1 cycle per committed change. The minimum spacing between commits is 3 `enter` edges.
- `stored_comb` is sampled combinationally in the comparison cycle. The new combination takes effect for entries made after COMMIT.

## Test plan
- Correct entry:
  - After reset, set `x`=0110 and pulse `enter`.
  - Required: `unlocked`=1 for 8 cycles, then 0. `fail_cnt` stays 0.
- Lockout:
  - Make three `enter` pulses with `x`=0001.
  - Required: `fail_cnt` goes 1, 2, then `alarm`=1 for 16 cycles.
  - Required: an `enter` pulse with 0110 during lockout is ignored.
  - Required: `alarm` and `fail_cnt` are 0 afterwards.
- Change success:
  - From OPEN, pulse `change`, then `enter` with `x`=1010, then `enter` with `x`=1010.
  - Required: `comb_out`=1010 and a single 1-cycle `set_comb` pulse.
  - Required: a later entry of 1010 against the updated `stored_comb` unlocks.
- Change mismatch or abort:
  - Confirm with 1011 instead of 1010: required return to LOCKED with no `set_comb` pulse.
  - Separately, pulse `change` in CHG_NEW: required abort to LOCKED.
- Reset mid-change:
  - Assert `Reset` in CHG_CONFIRM.
  - Required: all outputs return to reset values, `comb_out`=0110, and no strobe is issued.
- Held key and priority:
  - Hold `enter` high for 10 cycles: required single action only.
  - Raise `enter` and `change` in the same cycle in OPEN: required transition to CHG_NEW.
